cpu_trace_recorder: RTL
=======================

// Module: cpu_trace_recorder
// PURPOSE
//  Hardware successor to the per-cycle PC/register dump used in CPU simulation.
//  Snoops the CPU's PC and register-file write port and records trace entries into
//  a parametrised circular buffer. Entries drain oldest-first over a valid/ready port.
//  Stops itself after a programmable cycle budget. Sits beside CPU, fed from PC and Registers.
// PARAMETERS
//  XLEN        32    PC / register data width
//  DEPTH       16    trace buffer entries (power of two, >=2)
//  CW          16    cycle-stamp width
//  MAX_CYCLES  256   cycles recorded per run before DONE (1..2**CW)
//  WRAP        0     1: overwrite oldest when full; 0: drop newest when full
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_i        in   1        asynchronous reset, active-low
//  start_i      in   1        level; IDLE->RUN while high
//  clear_i      in   1        pulse; flush buffer, return to IDLE (any state)
//  mode_i       in   1        0: record every cycle; 1: record reg writes only; sampled on IDLE->RUN
//  pc_i         in   XLEN     current PC
//  rf_we_i      in   1        register-file write enable
//  rf_waddr_i   in   5        register-file write address
//  rf_wdata_i   in   XLEN     register-file write data
//  rd_valid_o   out  1        oldest entry available
//  rd_ready_i   in   1        consumer accepts entry (pop when valid&ready)
//  rd_data_o    out  EW       {cycle[CW], pc[XLEN], we, waddr[5], wdata[XLEN]}; EW=CW+2*XLEN+6
//  level_o      out  log2(DEPTH)+1  entries held
//  overflow_o   out  1        sticky; an entry was lost (dropped or overwritten)
//  done_o       out  1        high in DONE
//  cycle_o      out  CW       cycles counted in current run
// BEHAVIOUR
//  - Reset (rst_i=0, async): state IDLE, pointers/level 0, cycle_o 0, overflow_o 0,
//    done_o 0, rd_valid_o 0, mode latched 0. rd_data_o don't-care while rd_valid_o=0.
//  - FSM: IDLE -(start_i)-> RUN -(cycle_o==MAX_CYCLES-1 at edge)-> DONE -(clear_i)-> IDLE.
//    clear_i has priority over all transitions and over capture/pop in that cycle.
//  - RUN, per rising edge: capture cond = (mode==0) | (rf_we_i & rf_waddr_i!=0);
//    if cond, write {cycle_o, pc_i, rf_we_i & (rf_waddr_i!=0), rf_waddr_i, rf_wdata_i};
//    cycle_o increments every RUN cycle (captured or not). Last capture is at stamp MAX_CYCLES-1.
//  - Writes to x0 never set the we field and never trigger capture in mode 1.
//  - IDLE/DONE: no capture; cycle_o holds (DONE) or is 0 (IDLE). Draining continues in DONE.
//  - Latency: an entry captured at edge N is visible on rd_data_o/rd_valid_o after edge N.
//  - rd_valid_o = (level_o!=0); rd_data_o = buffer[rd_ptr], stable while valid & !ready.
//  - Push & pop same cycle: both occur, level unchanged (including when full: no overflow).
//  - Full, push, no pop: WRAP=1 -> write at wr_ptr, advance wr_ptr and rd_ptr, level stays
//    DEPTH, overflow_o<=1. WRAP=0 -> entry discarded, buffer unchanged, overflow_o<=1.
//  - Pop when empty: ignored. Pointers wrap modulo DEPTH.
//  - overflow_o cleared only by reset or clear_i. Reset mid-run aborts immediately, all data lost.
//  - start_i held high in DONE does not restart; clear_i is required.
// STRUCTURE
//  - trace_pkg: entry field offsets/widths, EW function, FSM state enum {IDLE,RUN,DONE}.
//  - Sub-module trace_fifo: DEPTH x EW circular buffer with wrap/drop policy, level, async read.
//  - cpu_trace_recorder: FSM, cycle counter, capture filter, entry packing.
// TESTING
//  1 Mode 0, MAX_CYCLES=8, DEPTH=16, rd_ready=1 after done: 8 entries, stamps 0..7, done_o=1, overflow_o=0.
//  2 Mode 1, writes x5=7 @cyc2, x0=9 @cyc3, x6=3 @cyc5: exactly 2 entries {2,..,1,5,7},{5,..,1,6,3}.
//  3 WRAP=0, DEPTH=4, mode 0, 6 cycles, no pop: level 4, stamps 0..3 held, overflow_o=1.
//  4 WRAP=1, same stimulus: level 4, stamps 2..5 held oldest-first, overflow_o=1.
//  5 Full buffer, push with rd_ready=1 same cycle: level stays 4, overflow_o stays 0.
//  6 rst_i low mid-RUN (cycle 3): outputs return to reset values without a clock edge;
//    clear_i in DONE -> IDLE, level 0, overflow_o 0; start_i restarts at stamp 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the CPU trace recorder: FSM states and the trace-entry layout.
// Entry layout, LSB first: wdata[XLEN], waddr[5], we, pc[XLEN], cycle[CW].
package trace_pkg;

    localparam int REGA_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int entry_w(input int xlen, input int cw);
        return cw + 2 * xlen + REGA_W + 1;
    endfunction

    function automatic int off_waddr(input int xlen);
        return xlen;
    endfunction

    function automatic int off_we(input int xlen);
        return xlen + REGA_W;
    endfunction

    function automatic int off_pc(input int xlen);
        return xlen + REGA_W + 1;
    endfunction

    function automatic int off_cycle(input int xlen);
        return 2 * xlen + REGA_W + 1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// DEPTH x EW circular trace buffer with an asynchronous read of the oldest entry.
// When full, a push without a pop either overwrites the oldest entry (WRAP=1) or is dropped.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int EW    = 86,
    parameter bit WRAP  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [EW-1:0]          wdata_i,
    output logic [EW-1:0]          rdata_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          overflow;
    logic          full;
    logic          do_pop;
    logic          do_write;
    logic          drop;

    always_comb begin
        full     = (level == FULL_LVL);
        do_pop   = pop_i && (level != '0);
        drop     = push_i && full && !do_pop;
        // A full buffer still accepts a push when a pop frees the slot in the same cycle.
        do_write = push_i && (!full || do_pop || WRAP);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (clr_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop || (drop && WRAP))
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push_i && !do_pop && !full)
                level <= level + LVL_ONE;
            else if (!push_i && do_pop)
                level <= level - LVL_ONE;
            if (drop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write)
            mem[wr_ptr] <= wdata_i;
    end

    assign rdata_o    = mem[rd_ptr];
    assign valid_o    = (level != '0);
    assign level_o    = level;
    assign overflow_o = overflow;

endmodule

// File: rtl/cpu_trace_recorder.sv
// Snoops CPU PC and register-file writes and records stamped trace entries into a buffer
// drained oldest-first over valid/ready; stops after MAX_CYCLES recorded cycles.
module cpu_trace_recorder
    import trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 256,
    parameter bit WRAP       = 1'b0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             clear_i,
    input  logic                             mode_i,
    input  logic [XLEN-1:0]                  pc_i,
    input  logic                             rf_we_i,
    input  logic [REGA_W-1:0]                rf_waddr_i,
    input  logic [XLEN-1:0]                  rf_wdata_i,
    output logic                             rd_valid_o,
    input  logic                             rd_ready_i,
    output logic [entry_w(XLEN, CW)-1:0]     rd_data_o,
    output logic [$clog2(DEPTH):0]           level_o,
    output logic                             overflow_o,
    output logic                             done_o,
    output logic [CW-1:0]                    cycle_o
);

    localparam int EW = entry_w(XLEN, CW);
    localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] CYC_ONE  = CW'(1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cycle;
    logic          mode;
    logic          we_eff;
    logic          push;
    logic          pop;
    logic [EW-1:0] entry;

    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i) state_nxt = RUN;
                RUN:     if (cycle == LAST_CYC) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Mode is sampled only on the IDLE->RUN edge so a run records under one filter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle <= '0;
            mode  <= 1'b0;
        end else if (clear_i) begin
            cycle <= '0;
        end else begin
            if (state == RUN)
                cycle <= cycle + CYC_ONE;
            if (state == IDLE && start_i)
                mode <= mode_i;
        end
    end

    // Writes to x0 are architecturally void: no we flag and no capture in write-only mode.
    always_comb begin
        we_eff = rf_we_i && (rf_waddr_i != '0);
        push   = (state == RUN) && !clear_i && (!mode || we_eff);
        pop    = rd_ready_i && !clear_i;
        entry  = {cycle, pc_i, we_eff, rf_waddr_i, rf_wdata_i};
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .WRAP  (WRAP)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clear_i),
        .push_i     (push),
        .pop_i      (pop),
        .wdata_i    (entry),
        .rdata_o    (rd_data_o),
        .valid_o    (rd_valid_o),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    assign done_o  = (state == DONE);
    assign cycle_o = cycle;

endmodule
